clock_divider: RTL and testbench
================================

CLOCK_DIVIDER -- requirements
Module: clock_divider

Interface
REQ-001 The block SHALL have the parameter THRESHOLD, default 50_000_000, meaning the number of enabled clk cycles per half-period of dividedClk; the legal range is integer >= 1.
REQ-002 The block SHALL have the port clk, input, 1 bit, meaning the single system clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit, meaning the synchronous, active-high reset.
REQ-004 The block SHALL have the port enable, input, 1 bit, meaning count advance when high and freeze when low.
REQ-005 The block SHALL have the port dividedClk, output, 1 bit, meaning the registered divided clock (square wave).
REQ-006 The block SHALL have the port tick, output, 1 bit, meaning a one-clk-cycle pulse coincident with each dividedClk toggle; leaving it unconnected SHALL be legal.
REQ-007 The design SHALL have one clock domain only; reset is synchronous and active-high.

Function
REQ-010 The internal counter width SHALL be max(1, ceil(log2(THRESHOLD))) bits, unsigned; no arithmetic SHALL overflow for any legal THRESHOLD up to 2^32-1.
REQ-011 On a rising clk edge with reset=0 and enable=1:
- if counter /= THRESHOLD-1: counter increments by 1; dividedClk holds.
- if counter == THRESHOLD-1: counter wraps to 0; dividedClk inverts.
REQ-012 On a rising clk edge with reset=0 and enable=0, counter and dividedClk SHALL hold their values and tick SHALL be 0.
REQ-013 tick SHALL be registered and SHALL be 1 for exactly the cycle following the edge at which dividedClk changed; otherwise it is 0.
REQ-014 With enable held high, the dividedClk period SHALL be 2*THRESHOLD clk cycles at a 50% duty cycle (THRESHOLD=50_000_000 at 100 MHz gives 1 Hz).
REQ-015 After reset is released with enable high, the first dividedClk rise SHALL occur at the THRESHOLD-th enabled rising edge.
REQ-016 THRESHOLD=1 SHALL toggle dividedClk on every enabled edge (divide-by-2); the counter stays 0.
REQ-017 enable SHALL be sampled only at rising clk edges; pulses between edges have no effect.
REQ-018 Deasserting enable mid-count SHALL freeze the phase; on re-enable, counting SHALL resume from the held count with no lost or extra cycles.
REQ-019 dividedClk SHALL be driven directly from a flip-flop with no combinational path from inputs, so it is glitch-free.
REQ-020 An illegal THRESHOLD (< 1) SHALL cause an elaboration-time error.

Reset
REQ-030 When reset=1 at a rising clk edge: counter=0, dividedClk=0, tick=0, regardless of enable.
REQ-031 reset SHALL take priority over enable and over the wrap condition on the same edge.
REQ-032 Reset asserted mid-count SHALL discard the phase; counting restarts from 0 per REQ-015 after release.
REQ-033 Before the first reset, output values SHALL be unspecified; the bench SHALL apply reset first.

Verification
REQ-040 THRESHOLD=4, reset for 2 cycles, enable=1 -> dividedClk=0 for 4 edges, then 1 for 4, then 0; period 8 clk; tick pulses every 4 cycles.
REQ-041 THRESHOLD=4, enable=0 for 10 cycles after reset -> dividedClk stays 0 and tick stays 0 throughout.
REQ-042 THRESHOLD=5, enable=1 for 3 edges, 0 for 6 edges, then 1 -> first toggle after exactly 2 further enabled edges.
REQ-043 THRESHOLD=4, reset asserted while dividedClk=1 with counter at 2 -> next edge gives dividedClk=0 and counter=0; first rise 4 enabled edges after release.
REQ-044 THRESHOLD=1, enable=1 -> dividedClk alternates every clk edge and tick is constantly 1 after the first toggle.
REQ-045 THRESHOLD=50_000_000, 100 MHz clk, reset deasserted at ~23 ns and enable raised at ~67 ns -> dividedClk rises 0.5 s after the first enabled edge, with a period of 1 s.

Source files
------------

// File: rtl/clock_divider.sv
// Clock divider: produces a registered 50% duty square wave whose half-period
// is THRESHOLD enabled clk cycles. A one-cycle tick accompanies each toggle.
// Single clock domain, synchronous active-high reset.
//
// No handshake on this block: enable is a level qualifier sampled at each
// rising clk edge. tick is a registered strobe that is high for the single
// cycle following the edge at which dividedClk changed.

module clock_divider #(
    parameter int unsigned THRESHOLD = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic dividedClk,
    output logic tick
);

    // Counter only needs to reach THRESHOLD-1, so ceil(log2(THRESHOLD)) bits
    // suffice; THRESHOLD=1 still gets a 1-bit counter that never leaves 0.
    localparam int unsigned CW = (THRESHOLD > 1) ? $clog2(THRESHOLD) : 1;
    localparam logic [CW-1:0] LAST = CW'(THRESHOLD - 1);

    // A zero threshold has no meaningful half-period; stop elaboration.
    if (THRESHOLD == 0) begin : g_bad_threshold
        $error("clock_divider: THRESHOLD must be >= 1");
    end

    logic [CW-1:0] count;
    logic          at_last;

    // Terminal-count detect; compares against a constant, never overflows.
    always_comb begin
        at_last = (count == LAST);
    end

    // Phase counter, divided clock flop and toggle strobe; reset wins over all.
    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            dividedClk <= 1'b0;
            tick       <= 1'b0;
        end else if (enable) begin
            if (at_last) begin
                count      <= '0;
                dividedClk <= ~dividedClk;
                tick       <= 1'b1;
            end else begin
                count      <= count + 1'b1;
                tick       <= 1'b0;
            end
        end else begin
            // Frozen: phase and output hold, no toggle so no strobe.
            tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clock_divider.sv
// Testbench for clock_divider: four instances with different thresholds,
// compared every cycle against an arithmetic model built on the number of
// enabled edges seen since the last reset.

module tb_clock_divider;

    localparam int unsigned T0 = 4;
    localparam int unsigned T1 = 5;
    localparam int unsigned T2 = 1;
    localparam int unsigned T3 = 7;
    localparam int N = 4;

    // ---------------- clock / reset block ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] rst;
    logic [N-1:0] en;
    logic [N-1:0] dclk;
    logic [N-1:0] tk;

    clock_divider #(.THRESHOLD(T0)) u_d0 (.clk(clk), .reset(rst[0]), .enable(en[0]), .dividedClk(dclk[0]), .tick(tk[0]));
    clock_divider #(.THRESHOLD(T1)) u_d1 (.clk(clk), .reset(rst[1]), .enable(en[1]), .dividedClk(dclk[1]), .tick(tk[1]));
    clock_divider #(.THRESHOLD(T2)) u_d2 (.clk(clk), .reset(rst[2]), .enable(en[2]), .dividedClk(dclk[2]), .tick(tk[2]));
    clock_divider #(.THRESHOLD(T3)) u_d3 (.clk(clk), .reset(rst[3]), .enable(en[3]), .dividedClk(dclk[3]), .tick(tk[3]));

    // ---------------- reference model ----------------
    // n[i]: enabled edges since reset. dividedClk = floor(n/T) mod 2.
    // tick is high after an enabled edge that completed a half-period.
    longint unsigned n [N];
    bit              last_en [N];

    function automatic longint unsigned thr_of(input int i);
        case (i)
            0: thr_of = T0;
            1: thr_of = T1;
            2: thr_of = T2;
            default: thr_of = T3;
        endcase
    endfunction

    function automatic logic exp_dclk(input int i);
        exp_dclk = logic'((n[i] / thr_of(i)) % 2);
    endfunction

    function automatic logic exp_tick(input int i);
        exp_tick = last_en[i] && (n[i] > 0) && ((n[i] % thr_of(i)) == 0);
    endfunction

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Apply inputs, take one rising edge, advance the model, then compare.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] e, input bit glitch);
        rst = r;
        en  = e;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (rst[i]) begin
                n[i] = 0;
                last_en[i] = 0;
            end else if (en[i]) begin
                n[i]++;
                last_en[i] = 1;
            end else begin
                last_en[i] = 0;
            end
        end
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("dclk%0d", i), 32'(dclk[i]), 32'(exp_dclk(i)));
            check($sformatf("tick%0d", i), 32'(tk[i]), 32'(exp_tick(i)));
        end
        if (glitch) begin
            // Flip enable briefly between edges; must not be seen.
            en = ~en;
            #2;
            en = e;
        end
    endtask

    task automatic run_en(input int cycles, input logic [N-1:0] e);
        for (int c = 0; c < cycles; c++) step('0, e, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = '1;
        en  = '0;
        for (int i = 0; i < N; i++) begin
            n[i] = 0;
            last_en[i] = 0;
        end
        #1;

        // Reset for 2 cycles with enable high: outputs must be 0.
        step('1, '1, 1'b0);
        step('1, '1, 1'b0);
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst_dclk%0d", i), 32'(dclk[i]), 32'd0);
            check($sformatf("rst_tick%0d", i), 32'(tk[i]), 32'd0);
        end

        // Free-running: 0 for T edges, 1 for T, then 0 again.
        run_en(24, '1);

        // Enable low for 10 cycles after reset: nothing moves.
        step('1, '0, 1'b0);
        run_en(10, '0);
        check("r041_dclk0", 32'(dclk[0]), 32'd0);
        check("r041_tick0", 32'(tk[0]), 32'd0);

        // T=5: 3 enabled, 6 frozen, then the 2nd enabled edge toggles.
        step('1, '0, 1'b0);
        run_en(3, '1);
        run_en(6, '0);
        step('0, '1, 1'b0);
        check("r042_hold", 32'(dclk[1]), 32'd0);
        step('0, '1, 1'b0);
        check("r042_toggle", 32'(dclk[1]), 32'd1);
        check("r042_tick", 32'(tk[1]), 32'd1);

        // T=4: reach dividedClk=1 with counter 2, then reset.
        step('1, '0, 1'b0);
        run_en(6, '1);
        check("r043_pre", 32'(dclk[0]), 32'd1);
        step('1, '1, 1'b0);
        check("r043_rst", 32'(dclk[0]), 32'd0);
        run_en(3, '1);
        check("r043_wait", 32'(dclk[0]), 32'd0);
        step('0, '1, 1'b0);
        check("r043_rise", 32'(dclk[0]), 32'd1);

        // T=1: toggles every edge, tick stays high.
        step('1, '1, 1'b0);
        for (int c = 0; c < 6; c++) begin
            step('0, '1, 1'b0);
            check("r044_tick", 32'(tk[2]), 32'd1);
        end

        // Randomized enables, between-edge glitches and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] r;
            logic [N-1:0] e;
            for (int i = 0; i < N; i++) begin
                r[i] = ($urandom_range(0, 59) == 0);
                e[i] = ($urandom_range(0, 3) != 0);
            end
            step(r, e, bit'($urandom_range(0, 4) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
